fft8_bfu_sequencer: RTL and testbench
=====================================

FFT8_BFU_SEQUENCER -- requirements
Module: fft8_bfu_sequencer

Interface
REQ-001 Parameter: DW, 32, sample component width (two's complement signed).
REQ-002 Port: clk  input  1  sole clock; all state changes on rising edge.
REQ-003 Port: rst  input  1  asynchronous, active-high reset.
REQ-004 Port: in_valid  input  1  input sample offered.
REQ-005 Port: in_ready  output  1  sequencer accepts input sample this cycle.
REQ-006 Port: in_real, in_imag  input  DW each  input sample, time-domain order x[0]..x[7].
REQ-007 Port: bf_a_real, bf_a_imag, bf_b_real, bf_b_imag  output  DW each  butterfly operands to downstream BFU.
REQ-008 Port: bf_sel_w  output  2  twiddle select to BFU (W8^0..W8^3).
REQ-009 Port: bf_x0_real, bf_x0_imag, bf_x1_real, bf_x1_imag  input  DW each  combinational BFU results for current operands.
REQ-010 Port: out_valid  output  1  output bin presented.
REQ-011 Port: out_ready  input  1  consumer accepts output bin.
REQ-012 Port: out_real, out_imag  output  DW each  output bin, natural order X[0]..X[7].
REQ-013 Port: busy  output  1  high in COMPUTE and OUTPUT.
REQ-014 Port: done  output  1  one-cycle pulse on acceptance of X[7].

Function
REQ-015 Storage: 8-entry complex register file, DW per component, written in place.
REQ-016 States: LOAD, COMPUTE, OUTPUT; encoding free.
REQ-017 LOAD: in_ready=1; on in_valid&in_ready, sample n (n = 3-bit load counter) written to entry bitrev(n) (e.g. n=1 -> 4, n=3 -> 6); counter increments.
REQ-018 LOAD -> COMPUTE on the cycle the 8th sample (n=7) is accepted; counter wraps to 0.
REQ-019 COMPUTE: 12 cycles, stage s=0..2 outer, butterfly k=0..3 inner, one butterfly per cycle, no gaps.
REQ-020 Index rule: span=2^s, pos=k mod span, grp=k div span; top=grp*2*span+pos; bot=top+span; bf_sel_w=pos*2^(2-s).
REQ-021 bf_a_* = entry[top], bf_b_* = entry[bot], bf_sel_w driven from state registers (no input-to-output combinational path except none).
REQ-022 At the rising edge ending each COMPUTE cycle: entry[top] <= bf_x0_*, entry[bot] <= bf_x1_*, values stored verbatim (no scaling, rounding or saturation; BFU owns arithmetic).
REQ-023 Outside COMPUTE, bf_* outputs SHALL be 0 (bf_sel_w=0); BFU results ignored.
REQ-024 COMPUTE -> OUTPUT after the write of s=2, k=3; first out_valid the following cycle.
REQ-025 OUTPUT: out_valid=1, out_* = entry[m] for output counter m; on out_valid&out_ready m increments; out_* stable while out_ready=0.
REQ-026 Acceptance of m=7: done=1 that cycle, transition to LOAD, in_ready=1 next cycle.
REQ-027 in_ready=0 and input ignored in COMPUTE and OUTPUT; out_valid=0 in LOAD and COMPUTE.
REQ-028 Minimum frame latency: last input accepted -> first out_valid = 13 cycles (12 compute + 1).
REQ-029 busy = (state==COMPUTE)|(state==OUTPUT).

Reset
REQ-030 rst asserted: state=LOAD, all counters 0, register file 0, in_ready=0 while rst high, out_valid=0, busy=0, done=0, bf_* = 0.
REQ-031 rst asserted mid-LOAD, mid-COMPUTE or mid-OUTPUT discards the frame; first sample after release is treated as x[0].
REQ-032 in_ready SHALL rise on the first clock edge after rst deasserts.

Verification
REQ-033 Impulse x[0]=100+0j, x[1..7]=0, reference BFU (X0=A+W·B, X1=A-W·B) -> X[0..7] all 100+0j, done pulses once.
REQ-034 DC x[n]=100 for all n -> X[0]=800+0j, X[1..7]=0+0j.
REQ-035 Load x[n]=n -> bf operand trace for s=0 shows (top,bot)=(0,1),(2,3),(4,5),(6,7) holding (0,4),(2,6),(1,5),(3,7), bf_sel_w=0; s=2 bf_sel_w sequence 0,1,2,3.
REQ-036 Back-pressure: out_ready low 3 cycles at m=2 -> out_* holds X[2] unchanged, no bin lost or duplicated, done only on X[7].
REQ-037 rst pulsed at COMPUTE cycle 5 -> all outputs at reset values immediately; subsequent full impulse frame yields REQ-033 result.
REQ-038 in_valid held high through COMPUTE/OUTPUT -> no samples accepted until LOAD; back-to-back frames produce correct independent results.

Source files
------------

// File: rtl/fft8_bfu_sequencer.sv
// In-place 8-point radix-2 DIT sequencer feeding an external combinational butterfly unit.
// Samples load bit-reversed, 3 stages x 4 butterflies run back to back, bins stream out in natural order.
module fft8_bfu_sequencer #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_real,
    input  logic [DW-1:0] in_imag,
    output logic [DW-1:0] bf_a_real,
    output logic [DW-1:0] bf_a_imag,
    output logic [DW-1:0] bf_b_real,
    output logic [DW-1:0] bf_b_imag,
    output logic [1:0]    bf_sel_w,
    input  logic [DW-1:0] bf_x0_real,
    input  logic [DW-1:0] bf_x0_imag,
    input  logic [DW-1:0] bf_x1_real,
    input  logic [DW-1:0] bf_x1_imag,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_real,
    output logic [DW-1:0] out_imag,
    output logic          busy,
    output logic          done
);

    typedef enum logic [1:0] {ST_LOAD, ST_COMPUTE, ST_OUTPUT} state_t;

    state_t        state, state_nxt;
    logic [DW-1:0] mem_re [8];
    logic [DW-1:0] mem_im [8];
    logic [2:0]    ld_cnt;
    logic [2:0]    out_cnt;
    logic [1:0]    stage;
    logic [1:0]    bfk;
    logic          rst_done;
    logic [2:0]    top, bot;
    logic [1:0]    sel;
    logic [2:0]    ld_addr;

    assign ld_addr  = {ld_cnt[0], ld_cnt[1], ld_cnt[2]};
    assign out_real = mem_re[out_cnt];
    assign out_imag = mem_im[out_cnt];

    // Butterfly addressing: bit-slice form of top = grp*2*span + pos, twiddle = pos*2^(2-s).
    always_comb begin
        top = '0;
        bot = '0;
        sel = '0;
        case (stage)
            2'd0: begin
                top = {bfk, 1'b0};
                bot = {bfk, 1'b1};
                sel = '0;
            end
            2'd1: begin
                top = {bfk[1], 1'b0, bfk[0]};
                bot = {bfk[1], 1'b1, bfk[0]};
                sel = {bfk[0], 1'b0};
            end
            default: begin
                top = {1'b0, bfk};
                bot = {1'b1, bfk};
                sel = bfk;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_LOAD;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        bf_a_real = '0;
        bf_a_imag = '0;
        bf_b_real = '0;
        bf_b_imag = '0;
        bf_sel_w  = '0;
        case (state)
            ST_LOAD: begin
                in_ready = rst_done;
                if (in_valid && rst_done && ld_cnt == 3'd7) state_nxt = ST_COMPUTE;
            end
            ST_COMPUTE: begin
                busy      = 1'b1;
                bf_a_real = mem_re[top];
                bf_a_imag = mem_im[top];
                bf_b_real = mem_re[bot];
                bf_b_imag = mem_im[bot];
                bf_sel_w  = sel;
                if (stage == 2'd2 && bfk == 2'd3) state_nxt = ST_OUTPUT;
            end
            ST_OUTPUT: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready && out_cnt == 3'd7) begin
                    done      = 1'b1;
                    state_nxt = ST_LOAD;
                end
            end
            default: state_nxt = ST_LOAD;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ld_cnt   <= '0;
            out_cnt  <= '0;
            stage    <= '0;
            bfk      <= '0;
            rst_done <= 1'b0;
            mem_re   <= '{default: '0};
            mem_im   <= '{default: '0};
        end else begin
            rst_done <= 1'b1;
            case (state)
                ST_LOAD: begin
                    if (in_valid && in_ready) begin
                        mem_re[ld_addr] <= in_real;
                        mem_im[ld_addr] <= in_imag;
                        ld_cnt          <= ld_cnt + 3'd1;
                    end
                end
                ST_COMPUTE: begin
                    mem_re[top] <= bf_x0_real;
                    mem_im[top] <= bf_x0_imag;
                    mem_re[bot] <= bf_x1_real;
                    mem_im[bot] <= bf_x1_imag;
                    bfk         <= bfk + 2'd1;
                    if (bfk == 2'd3) stage <= (stage == 2'd2) ? 2'd0 : stage + 2'd1;
                end
                ST_OUTPUT: begin
                    if (out_ready) out_cnt <= out_cnt + 3'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fft8_bfu_sequencer.sv
// Bench for fft8_bfu_sequencer: fixed-point reference BFU in the loop, table vectors,
// hand-written corner sequences and randomized frames checked against a loop-based FFT model.
module tb_fft8_bfu_sequencer;

    localparam int DW = 32;
    typedef logic signed [DW-1:0] word_t;
    typedef word_t vec_t [8];
    typedef struct packed {
        logic [7:0][DW-1:0] xr;
        logic [7:0][DW-1:0] xi;
        logic [7:0][DW-1:0] er;
        logic [7:0][DW-1:0] ei;
        logic [1:0]         mode;
        logic               gaps;
    } rec_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid, in_ready, out_valid, out_ready, busy, done;
    logic [DW-1:0] in_real, in_imag, out_real, out_imag;
    logic [DW-1:0] bf_a_real, bf_a_imag, bf_b_real, bf_b_imag;
    logic [DW-1:0] bf_x0_real, bf_x0_imag, bf_x1_real, bf_x1_imag;
    logic [1:0]    bf_sel_w;
    logic [4*DW-1:0] bfu_res;

    int   n_cmp = 0;
    int   n_err = 0;
    bit   hold_junk = 0;
    bit   expect_ready = 0;
    vec_t exp_r, exp_i;
    word_t tr_ar [12], tr_ai [12], tr_br [12], tr_bi [12];
    logic [1:0] tr_sel [12];
    word_t obs_ar [12], obs_br [12];
    logic [1:0] obs_sel [12];
    rec_t tbl [4];
    int   ramp_top [4] = '{0, 2, 1, 3};
    int   ramp_bot [4] = '{4, 6, 5, 7};

    fft8_bfu_sequencer #(.DW(DW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_real(in_real), .in_imag(in_imag),
        .bf_a_real(bf_a_real), .bf_a_imag(bf_a_imag), .bf_b_real(bf_b_real), .bf_b_imag(bf_b_imag),
        .bf_sel_w(bf_sel_w),
        .bf_x0_real(bf_x0_real), .bf_x0_imag(bf_x0_imag), .bf_x1_real(bf_x1_real), .bf_x1_imag(bf_x1_imag),
        .out_valid(out_valid), .out_ready(out_ready), .out_real(out_real), .out_imag(out_imag),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Reference BFU: X0 = A + W*B, X1 = A - W*B, W8^k with 8 fractional bits (181/256 ~ 1/sqrt2).
    function automatic logic [4*DW-1:0] bfu(input word_t ar, input word_t ai, input word_t br,
                                            input word_t bi, input logic [1:0] w);
        longint wr, wi, pr, pi;
        case (w)
            2'd0:    begin wr = 256;  wi = 0;    end
            2'd1:    begin wr = 181;  wi = -181; end
            2'd2:    begin wr = 0;    wi = -256; end
            default: begin wr = -181; wi = -181; end
        endcase
        pr = (longint'(br) * wr - longint'(bi) * wi) >>> 8;
        pi = (longint'(br) * wi + longint'(bi) * wr) >>> 8;
        return {word_t'(longint'(ar) + pr), word_t'(longint'(ai) + pi),
                word_t'(longint'(ar) - pr), word_t'(longint'(ai) - pi)};
    endfunction

    always_comb bfu_res = bfu(bf_a_real, bf_a_imag, bf_b_real, bf_b_imag, bf_sel_w);
    assign {bf_x0_real, bf_x0_imag, bf_x1_real, bf_x1_imag} = bfu_res;

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Textbook in-place DIT FFT on an array, recording the operand trace it implies.
    task automatic model(input vec_t xr, input vec_t xi);
        vec_t er, ei;
        int c, rv, span, pos, grp, tp, bt, w;
        logic [4*DW-1:0] r;
        c = 0;
        for (int n = 0; n < 8; n++) begin
            rv = ((n & 1) << 2) | (n & 2) | ((n >> 2) & 1);
            er[rv] = xr[n];
            ei[rv] = xi[n];
        end
        for (int s = 0; s < 3; s++) begin
            for (int k = 0; k < 4; k++) begin
                span = 1 << s;
                pos  = k % span;
                grp  = k / span;
                tp   = grp * 2 * span + pos;
                bt   = tp + span;
                w    = pos * (1 << (2 - s));
                tr_ar[c] = er[tp]; tr_ai[c] = ei[tp];
                tr_br[c] = er[bt]; tr_bi[c] = ei[bt];
                tr_sel[c] = w[1:0];
                r = bfu(er[tp], ei[tp], er[bt], ei[bt], w[1:0]);
                er[tp] = r[4*DW-1:3*DW]; ei[tp] = r[3*DW-1:2*DW];
                er[bt] = r[2*DW-1:DW];   ei[bt] = r[DW-1:0];
                c++;
            end
        end
        exp_r = er;
        exp_i = ei;
    endtask

    task automatic load_frame(input vec_t xr, input vec_t xi, input bit gaps);
        int n = 0;
        int guard = 0;
        while (n < 8 && guard < 200) begin
            @(negedge clk);
            guard++;
            if (expect_ready) begin
                chk("in_ready_rise", in_ready, 1);
                expect_ready = 0;
            end
            chk("load_status", {out_valid, busy, done}, 0);
            if (gaps && $urandom_range(0, 3) == 0) begin
                in_valid = 0; in_real = $urandom; in_imag = $urandom;
            end else begin
                in_valid = 1; in_real = xr[n]; in_imag = xi[n];
                if (in_ready) n++;
            end
        end
        if (n < 8) chk("load_timeout", n, 8);
    endtask

    task automatic compute_phase();
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (hold_junk) begin in_valid = 1; in_real = $urandom; in_imag = $urandom; end
            else in_valid = 0;
            chk("compute_status", {in_ready, out_valid, busy, done}, 4'b0010);
            chk($sformatf("bf_a_real[%0d]", c), $signed(bf_a_real), tr_ar[c]);
            chk($sformatf("bf_a_imag[%0d]", c), $signed(bf_a_imag), tr_ai[c]);
            chk($sformatf("bf_b_real[%0d]", c), $signed(bf_b_real), tr_br[c]);
            chk($sformatf("bf_b_imag[%0d]", c), $signed(bf_b_imag), tr_bi[c]);
            chk($sformatf("bf_sel_w[%0d]", c), bf_sel_w, tr_sel[c]);
            obs_ar[c] = bf_a_real; obs_br[c] = bf_b_real; obs_sel[c] = bf_sel_w;
        end
    endtask

    task automatic output_phase(input int mode);
        int m = 0;
        int guard = 0;
        int stall = 0;
        bit rdy;
        while (m < 8 && guard < 200) begin
            @(negedge clk);
            guard++;
            if (hold_junk) begin in_real = $urandom; in_imag = $urandom; end
            case (mode)
                0: rdy = 1;
                1: if (m == 2 && stall < 3) begin rdy = 0; stall++; end else rdy = 1;
                default: rdy = ($urandom_range(0, 2) != 0);
            endcase
            out_ready = rdy;
            #1;
            chk("output_status", {in_ready, out_valid, busy}, 3'b011);
            chk($sformatf("out_real[%0d]", m), $signed(out_real), exp_r[m]);
            chk($sformatf("out_imag[%0d]", m), $signed(out_imag), exp_i[m]);
            chk($sformatf("done@m%0d", m), done, (rdy && m == 7));
            if (out_valid && rdy) m++;
        end
        if (m < 8) chk("output_timeout", m, 8);
        expect_ready = 1;
    endtask

    task automatic run_frame(input vec_t xr, input vec_t xi, input bit use_given,
                             input vec_t gr, input vec_t gi, input bit gaps, input int mode);
        model(xr, xi);
        if (use_given) begin exp_r = gr; exp_i = gi; end
        load_frame(xr, xi, gaps);
        compute_phase();
        output_phase(mode);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_flags"}, {in_ready, out_valid, busy, done}, 0);
        chk({tag, "_bf"}, {bf_a_real, bf_a_imag, bf_b_real, bf_b_imag, bf_sel_w}, 0);
    endtask

    task automatic get_tbl(input int t, output vec_t xr, output vec_t xi, output vec_t er, output vec_t ei);
        for (int i = 0; i < 8; i++) begin
            xr[i] = tbl[t].xr[i]; xi[i] = tbl[t].xi[i];
            er[i] = tbl[t].er[i]; ei[i] = tbl[t].ei[i];
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t xr, xi, er, ei;
        rst = 1; in_valid = 0; out_ready = 0; in_real = '0; in_imag = '0;

        // impulse, DC, alternating sign, imaginary impulse
        for (int i = 0; i < 8; i++) begin
            tbl[0].xr[i] = (i == 0) ? 100 : 0;  tbl[0].xi[i] = 0;
            tbl[0].er[i] = 100;                 tbl[0].ei[i] = 0;
            tbl[1].xr[i] = 100;                 tbl[1].xi[i] = 0;
            tbl[1].er[i] = (i == 0) ? 800 : 0;  tbl[1].ei[i] = 0;
            tbl[2].xr[i] = (i % 2 == 0) ? 50 : -50; tbl[2].xi[i] = 0;
            tbl[2].er[i] = (i == 4) ? 400 : 0;  tbl[2].ei[i] = 0;
            tbl[3].xr[i] = 0;                   tbl[3].xi[i] = (i == 0) ? 100 : 0;
            tbl[3].er[i] = 0;                   tbl[3].ei[i] = 100;
        end
        tbl[0].mode = 0; tbl[0].gaps = 0;
        tbl[1].mode = 1; tbl[1].gaps = 0;
        tbl[2].mode = 2; tbl[2].gaps = 1;
        tbl[3].mode = 1; tbl[3].gaps = 1;

        @(negedge clk); @(negedge clk); #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst = 0;
        #1 chk("in_ready_before_edge", in_ready, 0);
        expect_ready = 1;

        for (int t = 0; t < 4; t++) begin
            get_tbl(t, xr, xi, er, ei);
            run_frame(xr, xi, 1, er, ei, tbl[t].gaps, int'(tbl[t].mode));
        end

        // ramp x[n]=n: operand trace of first and last stage
        for (int i = 0; i < 8; i++) begin xr[i] = i; xi[i] = 0; end
        run_frame(xr, xi, 0, er, ei, 0, 0);
        for (int c = 0; c < 4; c++) begin
            chk($sformatf("ramp_s0_top[%0d]", c), obs_ar[c], ramp_top[c]);
            chk($sformatf("ramp_s0_bot[%0d]", c), obs_br[c], ramp_bot[c]);
            chk($sformatf("ramp_s0_w[%0d]", c), obs_sel[c], 0);
            chk($sformatf("ramp_s2_w[%0d]", c), obs_sel[8 + c], c);
        end

        // reset during compute cycle 5, then a clean impulse frame
        get_tbl(0, xr, xi, er, ei);
        model(xr, xi);
        load_frame(xr, xi, 0);
        for (int c = 0; c < 5; c++) begin @(negedge clk); in_valid = 0; end
        #1 rst = 1;
        #1 check_reset_outputs("reset_mid_compute");
        @(negedge clk);
        rst = 0;
        #1 chk("in_ready_after_mid_reset", in_ready, 0);
        expect_ready = 1;
        run_frame(xr, xi, 1, er, ei, 0, 0);

        // reset after 3 loaded samples, then a DC frame must start at x[0]
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            in_valid = 1; in_real = 32'd7777; in_imag = 32'd3;
            expect_ready = 0;
        end
        @(negedge clk);
        in_valid = 0;
        #1 rst = 1;
        #1 check_reset_outputs("reset_mid_load");
        @(negedge clk);
        rst = 0;
        expect_ready = 1;
        get_tbl(1, xr, xi, er, ei);
        run_frame(xr, xi, 1, er, ei, 0, 0);

        // randomized frames; later ones keep in_valid high with junk outside LOAD
        for (int f = 0; f < 8; f++) begin
            hold_junk = (f >= 4);
            for (int i = 0; i < 8; i++) begin
                xr[i] = word_t'(int'($urandom_range(0, 2000)) - 1000);
                xi[i] = word_t'(int'($urandom_range(0, 2000)) - 1000);
            end
            run_frame(xr, xi, 0, er, ei, (f % 2 == 0), 2);
        end
        hold_junk = 0;

        @(negedge clk);
        in_valid = 0;
        chk("final_in_ready", in_ready, 1);
        chk("final_status", {out_valid, busy, done}, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
